// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Define SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN for two's complement operands.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] a_in, b_in, q_fin, r_fin;
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
`endif

  // Magnitudes go into the datapath; signs are reapplied at completion.
  always_comb begin
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
    a_in  = dividend[WIDTH-1] ? -dividend : dividend;
    b_in  = divisor[WIDTH-1] ? -divisor : divisor;
    q_fin = sq_q ? -dq_q : dq_q;
    r_fin = sr_q ? -acc_q : acc_q;
`else
    a_in  = dividend;
    b_in  = divisor;
    q_fin = dq_q;
    r_fin = acc_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
    sq_d    = sq_q;
    sr_d    = sr_q;
`endif
    shifted = {acc_q, dq_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          dvs_d = b_in;
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
          sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d  = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            // Preload the fault result so DONE publishes it unchanged.
            dq_d    = '1;
            acc_d   = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
            sq_d    = 1'b0;
            sr_d    = 1'b0;
`endif
          end else begin
            dq_d    = a_in;
            acc_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          acc_d = trial[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          dq_d  = {dq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        quo_d   = q_fin;
        rem_d   = r_fin;
        dbz_d   = dz_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
      sq_q    <= sq_d;
      sr_q    <= sr_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider, WIDTH=8.
// Signed vectors run when SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN is defined.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int n_done;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the next posedge.
  task automatic do_op(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output int l);
    logic seen;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'hAA;
    divisor  = 8'h00;
    chk("busy_acc", busy, 1);
    l    = 0;
    seen = 1'b0;
    while (!seen && l < 40) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic chk_res(input string tag,
                         input logic [W-1:0] q,
                         input logic [W-1:0] r,
                         input logic z,
                         input int l_exp);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_z"}, div_by_zero, z);
    chk({tag, "_lat"}, lat, l_exp);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[3];

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

`ifdef SEQ_RESTORING_DIVIDER_SIGNED_DIV_EN
    do_op(8'hF9, 8'h02, lat);
    chk_res("s_m7_2", 8'hFD, 8'hFF, 1'b0, W + 1);
    @(negedge clk);
    do_op(8'h80, 8'hFF, lat);
    chk_res("s_ovf", 8'h80, 8'h00, 1'b0, W + 1);
    @(negedge clk);
    do_op(8'h07, 8'hFE, lat);
    chk_res("s_7_m2", 8'hFD, 8'h01, 1'b0, W + 1);
    @(negedge clk);
    do_op(8'hFB, 8'h00, lat);
    chk_res("s_dz", 8'hFF, 8'hFB, 1'b1, 1);
`else
    do_op(8'd200, 8'd7, lat);
    chk_res("d200_7", 8'd28, 8'd4, 1'b0, W + 1);
    @(negedge clk);
    chk("pulse_done", done, 0);
    chk("pulse_busy", busy, 0);

    do_op(8'd5, 8'd0, lat);
    chk_res("dz", 8'hFF, 8'd5, 1'b1, 1);
    @(negedge clk);

    // Second request lands during the done cycle.
    do_op(8'd255, 8'd1, lat);
    chk_res("d255_1", 8'd255, 8'd0, 1'b0, W + 1);
    do_op(8'd9, 8'd10, lat);
    chk_res("b2b", 8'd0, 8'd9, 1'b0, W + 1);
    @(negedge clk);

    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      chk("ign_busy", busy, 1);
      chk("ign_hold", remainder, 9);
      if (k == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (k == 4) start = 1'b0;
    end
    @(negedge clk);
    chk("ign_done", done, 1);
    chk("ign_q", quotient, 33);
    chk("ign_r", remainder, 1);
    @(negedge clk);
    chk("ign_noq", busy, 0);

    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_z", div_by_zero, 0);
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_nodone", n_done, 0);
    do_op(8'd12, 8'd4, lat);
    chk_res("d12_4", 8'd3, 8'd0, 1'b0, W + 1);
    @(negedge clk);

    vecs[0] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,  r: 8'd0};
    vecs[1] = '{a: 8'd250, b: 8'd16,  q: 8'd15, r: 8'd10};
    vecs[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,  r: 8'd0};
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      chk_res("tbl", vecs[i].q, vecs[i].r, 1'b0, W + 1);
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
